bht_predictor: RTL and testbench
================================

BHT_PREDICTOR -- requirements
Module: bht_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, number of counters; power of two, 2..1024.
REQ-002 SHALL have parameter CNT_W, default 2, counter width; 2..4.
REQ-003 SHALL have parameter IDX_W, default $clog2(ENTRIES), table index width; derived, not overridden.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port lookup_pc  input  32  PC of the branch in IF/ID.
REQ-007 SHALL have port predict_taken  output  1  prediction for lookup_pc; combinational.
REQ-008 SHALL have port lookup_idx  output  IDX_W  index used for the lookup; carried down the pipe.
REQ-009 SHALL have port update_valid  input  1  resolved branch in EX this cycle.
REQ-010 SHALL have port update_idx  input  IDX_W  lookup_idx carried with the resolving branch.
REQ-011 SHALL have port update_taken  input  1  actual outcome.
REQ-012 SHALL have port update_pred  input  1  prediction made for that branch.
REQ-013 SHALL have port mispredict  output  1  update_valid & (update_taken != update_pred); combinational.
REQ-014 SHALL have port mispredict_cnt  output  16  registered count of mispredicts.

Function
REQ-015 SHALL hold ENTRIES counters of CNT_W bits each; TAKEN_THR = 2^(CNT_W-1).
REQ-016 SHALL compute base index as lookup_pc[IDX_W+1:2]; PC bits [1:0] ignored.
REQ-017 SHALL drive predict_taken = (counter[lookup_idx] >= TAKEN_THR), i.e. counter MSB.
REQ-018 SHALL, on update_valid with update_taken=1, increment counter[update_idx], saturating at 2^CNT_W-1.
REQ-019 SHALL, on update_valid with update_taken=0, decrement counter[update_idx], saturating at 0.
REQ-020 SHALL leave all counters unchanged when update_valid=0.
REQ-021 SHALL, when update_idx equals lookup_idx in the same cycle, predict from the pre-update value (no bypass); the new value is visible the next cycle.
REQ-022 SHALL increment mispredict_cnt by one on each cycle mispredict=1, saturating at 16'hFFFF.
REQ-023 SHALL ignore update_pc-free aliasing: distinct PCs sharing an index share a counter.

Reset
REQ-024 SHALL, when rst=1 at a rising edge, set every counter to TAKEN_THR (weakly taken), mispredict_cnt to 0, and GHR (if present) to 0.
REQ-025 SHALL give rst priority over a simultaneous update_valid; that update is discarded.
REQ-026 SHALL produce predict_taken=1 for any PC in the first cycle after reset.

Configuration
REQ-027 SHALL, with macro BHT_GSHARE_EN defined, keep an IDX_W-bit global history register GHR and use lookup_idx = base index XOR GHR.
REQ-028 SHALL, with BHT_GSHARE_EN, shift update_taken into GHR LSB on each update_valid (GHR <= {GHR[IDX_W-2:0], update_taken}).
REQ-029 SHALL, without BHT_GSHARE_EN, use lookup_idx = base index and contain no GHR.

Structure
REQ-030 SHALL place counter-encoding constants and saturating increment/decrement functions in package bp_pkg.
REQ-031 SHALL implement one counter as sub-module sat_counter (CNT_W param, inc/dec/rst inputs), instantiated ENTRIES times via generate.

Verification
REQ-032 SHALL test: reset, lookup_pc=0x40 -> predict_taken=1, lookup_idx=0, mispredict_cnt=0.
REQ-033 SHALL test: CNT_W=2, three not-taken updates at idx 0 -> counter 0, predict_taken=0; one further not-taken -> counter stays 0.
REQ-034 SHALL test: five taken updates at idx 3 -> counter 3 (saturated), predict_taken=1 for lookup_pc=0x0C.
REQ-035 SHALL test: update_idx=lookup_idx=5, counter=2, update_taken=0 same cycle -> predict_taken=1 that cycle, 0 next cycle.
REQ-036 SHALL test: 70000 mispredicting updates -> mispredict_cnt=16'hFFFF; rst asserted with update_valid=1 -> counters=TAKEN_THR, cnt=0.
REQ-037 SHALL test (BHT_GSHARE_EN, ENTRIES=16): updates taken,taken -> GHR=4'b0011; lookup_pc=0x10 -> lookup_idx=4'b0111.

Source files
------------

// File: rtl/bp_pkg.sv
//============================================================================
// Module : bp_pkg
// Brief  : Saturating-counter encoding constants and helpers for the BHT.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

package bp_pkg;

    // Helpers work on the widest supported counter; callers cast to CNT_W.
    localparam int c_cnt_w_max = 4;

    typedef logic [c_cnt_w_max-1:0] cnt_t;

    function automatic cnt_t cnt_max(input int w);
        return cnt_t'((1 << w) - 1);
    endfunction

    function automatic cnt_t taken_thr(input int w);
        return cnt_t'(1 << (w - 1));
    endfunction

    function automatic cnt_t sat_inc(input cnt_t v, input cnt_t max);
        return (v == max) ? v : v + cnt_t'(1);
    endfunction

    function automatic cnt_t sat_dec(input cnt_t v);
        return (v == '0) ? v : v - cnt_t'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
//============================================================================
// Module : sat_counter
// Brief  : One CNT_W-bit saturating up/down counter, resets to weakly taken.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module sat_counter
    import bp_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] value
);

    localparam cnt_t c_max = cnt_max(CNT_W);

    logic [CNT_W-1:0] r_cnt;
    cnt_t             w_ext;

    assign w_ext = cnt_t'(r_cnt);
    assign value = r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= CNT_W'(taken_thr(CNT_W));
        end else if (inc) begin
            r_cnt <= CNT_W'(sat_inc(w_ext, c_max));
        end else if (dec) begin
            r_cnt <= CNT_W'(sat_dec(w_ext));
        end
    end

endmodule

`default_nettype wire

// File: rtl/bht_predictor.sv
//============================================================================
// Module : bht_predictor
// Brief  : Branch history table of saturating counters with mispredict count.
//          Define BHT_GSHARE_EN to XOR a global history register into the index.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module bht_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      lookup_pc,
    output logic             predict_taken,
    output logic [IDX_W-1:0] lookup_idx,
    input  logic             update_valid,
    input  logic [IDX_W-1:0] update_idx,
    input  logic             update_taken,
    input  logic             update_pred,
    output logic             mispredict,
    output logic [15:0]      mispredict_cnt
);

    logic [IDX_W-1:0] w_base_idx;
    logic [CNT_W-1:0] w_cnt [ENTRIES];
    logic [15:0]      r_mp_cnt;
    logic             w_pc_unused;

    assign w_base_idx  = lookup_pc[IDX_W+1:2];
    assign w_pc_unused = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0]};

`ifdef BHT_GSHARE_EN
    logic [IDX_W-1:0] r_ghr;

    // Cast keeps the shift legal when IDX_W is 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ghr <= '0;
        end else if (update_valid) begin
            r_ghr <= IDX_W'({r_ghr, update_taken});
        end
    end

    assign lookup_idx = w_base_idx ^ r_ghr;
`else
    assign lookup_idx = w_base_idx;
`endif

    genvar i;
    generate
        for (i = 0; i < ENTRIES; i++) begin : g_ctr
            logic w_hit;
            assign w_hit = update_valid && (update_idx == IDX_W'(i));

            sat_counter #(
                .CNT_W (CNT_W)
            ) u_ctr (
                .clk   (clk),
                .rst   (rst),
                .inc   (w_hit &  update_taken),
                .dec   (w_hit & ~update_taken),
                .value (w_cnt[i])
            );
        end
    endgenerate

    // Reads the registered value, so a same-cycle update is seen next cycle.
    assign predict_taken = w_cnt[lookup_idx][CNT_W-1];

    assign mispredict = update_valid && (update_taken != update_pred);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mp_cnt <= '0;
        end else if (mispredict && (r_mp_cnt != 16'hFFFF)) begin
            r_mp_cnt <= r_mp_cnt + 16'd1;
        end
    end

    assign mispredict_cnt = r_mp_cnt;

endmodule

`default_nettype wire

// File: tb/tb_bht_predictor.sv
//============================================================================
// Module : tb_bht_predictor
// Brief  : Directed self-checking bench for bht_predictor (default params).
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module tb_bht_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] lookup_pc;
    logic        predict_taken;
    logic [3:0]  lookup_idx;
    logic        update_valid;
    logic [3:0]  update_idx;
    logic        update_taken;
    logic        update_pred;
    logic        mispredict;
    logic [15:0] mispredict_cnt;

    int n_tests;
    int n_fail;
    logic [3:0] model_ghr;

    bht_predictor dut (
        .clk            (clk),
        .rst            (rst),
        .lookup_pc      (lookup_pc),
        .predict_taken  (predict_taken),
        .lookup_idx     (lookup_idx),
        .update_valid   (update_valid),
        .update_idx     (update_idx),
        .update_taken   (update_taken),
        .update_pred    (update_pred),
        .mispredict     (mispredict),
        .mispredict_cnt (mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pick a PC whose effective index (after history hashing) is idx.
    task automatic set_lookup(input logic [3:0] idx);
        lookup_pc = 32'({idx ^ model_ghr, 2'b00});
        #1;
    endtask

    task automatic do_update(input logic [3:0] idx, input logic taken, input logic pred);
        update_valid = 1'b1;
        update_idx   = idx;
        update_taken = taken;
        update_pred  = pred;
        tick();
        update_valid = 1'b0;
`ifdef BHT_GSHARE_EN
        model_ghr = {model_ghr[2:0], taken};
`endif
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        model_ghr    = '0;
        rst          = 1'b1;
        lookup_pc    = '0;
        update_valid = 1'b0;
        update_idx   = '0;
        update_taken = 1'b0;
        update_pred  = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        lookup_pc = 32'h40;
        #1;
        check_eq("rst_pred", 32'(predict_taken), 1);
        check_eq("rst_idx", 32'(lookup_idx), 0);
        check_eq("rst_cnt", 32'(mispredict_cnt), 0);
        check_eq("idle_mp", 32'(mispredict), 0);

        // Saturate low at idx 0
        for (int k = 0; k < 3; k++) do_update(4'd0, 1'b0, 1'b0);
        set_lookup(4'd0);
        check_eq("low_pred", 32'(predict_taken), 0);
        do_update(4'd0, 1'b0, 1'b0);
        do_update(4'd0, 1'b1, 1'b1);
        set_lookup(4'd0);
        check_eq("low_sat", 32'(predict_taken), 0);
        do_update(4'd0, 1'b1, 1'b1);
        set_lookup(4'd0);
        check_eq("low_recover", 32'(predict_taken), 1);
        check_eq("no_mp_cnt", 32'(mispredict_cnt), 0);

        // Saturate high at idx 3
        for (int k = 0; k < 5; k++) begin
            do_update(4'd3, 1'b1, 1'b1);
            set_lookup(4'd3);
            check_eq("high_pred", 32'(predict_taken), 1);
        end
        do_update(4'd3, 1'b0, 1'b0);
        set_lookup(4'd3);
        check_eq("high_dec1", 32'(predict_taken), 1);
        do_update(4'd3, 1'b0, 1'b0);
        set_lookup(4'd3);
        check_eq("high_dec2", 32'(predict_taken), 0);

        // Same-cycle update/lookup at idx 5: no bypass
        set_lookup(4'd5);
        update_valid = 1'b1;
        update_idx   = 4'd5;
        update_taken = 1'b0;
        update_pred  = 1'b1;
        #1;
        check_eq("nobyp_same", 32'(predict_taken), 1);
        check_eq("mp_comb", 32'(mispredict), 1);
        tick();
        update_valid = 1'b0;
`ifdef BHT_GSHARE_EN
        model_ghr = {model_ghr[2:0], 1'b0};
`endif
        set_lookup(4'd5);
        check_eq("nobyp_next", 32'(predict_taken), 0);
        check_eq("mp_cnt1", 32'(mispredict_cnt), 1);

        // Mispredict counter saturation
        update_valid = 1'b1;
        update_idx   = 4'd7;
        update_taken = 1'b1;
        update_pred  = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check_eq("mp_cnt11", 32'(mispredict_cnt), 11);
        for (int k = 0; k < 69990; k++) tick();
        check_eq("mp_cnt_sat", 32'(mispredict_cnt), 32'hFFFF);

        // Reset wins over a simultaneous update
        rst          = 1'b1;
        update_idx   = 4'd0;
        update_taken = 1'b0;
        tick();
        rst          = 1'b0;
        update_valid = 1'b0;
        model_ghr    = '0;
        check_eq("rst2_cnt", 32'(mispredict_cnt), 0);
        set_lookup(4'd7);
        check_eq("rst2_idx7", 32'(predict_taken), 1);
        set_lookup(4'd0);
        check_eq("rst2_idx0", 32'(predict_taken), 1);
        do_update(4'd0, 1'b0, 1'b0);
        set_lookup(4'd0);
        check_eq("rst2_thr", 32'(predict_taken), 0);

        // Index hashing
`ifdef BHT_GSHARE_EN
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        model_ghr = '0;
        do_update(4'd9, 1'b1, 1'b1);
        do_update(4'd9, 1'b1, 1'b1);
        lookup_pc = 32'h10;
        #1;
        check_eq("gshare_idx", 32'(lookup_idx), 32'h7);
`else
        lookup_pc = 32'h10;
        #1;
        check_eq("base_idx", 32'(lookup_idx), 32'h4);
        lookup_pc = 32'hFFFF_FFC7;
        #1;
        check_eq("base_idx_hi", 32'(lookup_idx), 32'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
